// File: rtl/spi_axis_pkg.sv
// Shared types and constants for the SPI slave to AXI-Stream bridge.
// Imported by the synchroniser and the top level.
package spi_axis_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    localparam int SPI_BITS_PER_BYTE = 8;
    localparam int BIT_CNT_W = $clog2(SPI_BITS_PER_BYTE);
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous pin with a history FF
// that turns the synchronised level into single-cycle rise/fall events.
module sync_edge_detect
    import spi_axis_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the pin through the synchroniser and keep one cycle of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_slave_axis.sv
// SPI mode-0 slave: MOSI bytes to m_axis, s_axis bytes out on MISO.
// SPI pins are oversampled and edge-detected in the clk domain.
module spi_slave_axis
    import spi_axis_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic       rx_overrun,
    output logic       frame_abort
);

    localparam int FLUSH = SYNC_STAGES + 1;
    localparam int FW    = $clog2(FLUSH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_BITS_PER_BYTE - 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;
    logic unused_tlast;

    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic [7:0]           byte_q, byte_d;
    logic                 byte_vld_q, byte_vld_d;
    logic [7:0]           m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;
    logic                 miso_q, miso_d;
    logic                 overrun_q, overrun_d;
    logic                 abort_q, abort_d;
    logic [FW-1:0]        flush_q, flush_d;
    logic                 armed_q, armed_d;
    logic                 tx_load;
    logic [7:0]           rx_next;

    assign unused_tlast = s_axis_tlast;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (spi_sclk),
        .level_o(sclk_lvl_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (spi_cs_n),
        .level_o(cs_level),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // Plain synchroniser for MOSI, same depth as the edge-detected pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Next-state: FSM, shifters, m_axis output register and tx holding register.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        overrun_d  = overrun_q;
        abort_d    = 1'b0;
        tx_load    = 1'b0;
        rx_next    = {rx_shift_q[6:0], mosi_s};
        // Ignore a frame already in progress when reset is released.
        flush_d = (flush_q != FW'(FLUSH)) ? flush_q + 1'b1 : flush_q;
        armed_d = armed_q | ((flush_q == FW'(FLUSH)) & cs_level);

        if (m_tvalid_q && m_axis_tready) m_tvalid_d = 1'b0;
        if (byte_vld_q) begin
            if (!m_tvalid_q || m_axis_tready) begin
                m_tdata_d  = byte_q;
                m_tvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (s_axis_tvalid && !hold_vld_q) begin
            hold_d     = s_axis_tdata;
            hold_vld_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    tx_load   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                priority case (1'b1)
                    cs_rise: begin
                        state_d   = ST_IDLE;
                        abort_d   = (bit_cnt_q != '0);
                        bit_cnt_d = '0;
                    end
                    sclk_rise: begin
                        rx_shift_d = rx_next;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            byte_vld_d = 1'b1;
                            byte_d     = rx_next;
                        end
                    end
                    sclk_fall: begin
                        if (bit_cnt_q == '0) tx_load = 1'b1;
                        else tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        if (tx_load) begin
            tx_shift_d = hold_vld_q ? hold_q : IDLE_BYTE;
            if (hold_vld_q) hold_vld_d = 1'b0;
        end

        miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[7] : 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            miso_q     <= 1'b0;
            overrun_q  <= 1'b0;
            abort_q    <= 1'b0;
            flush_q    <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            miso_q     <= miso_d;
            overrun_q  <= overrun_d;
            abort_q    <= abort_d;
            flush_q    <= flush_d;
            armed_q    <= armed_d;
        end
    end

    assign spi_miso      = miso_q;
    assign spi_miso_oe   = (state_q == ST_ACTIVE);
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign s_axis_tready = ~hold_vld_q;
    assign rx_overrun    = overrun_q;
    assign frame_abort   = abort_q;

endmodule

// File: tb/tb_spi_slave_axis.sv
// Randomised bench for spi_slave_axis with a byte-level reference model:
// SPI host driver, m_axis monitor, expected queues built from frame contents.
module tb_spi_slave_axis;

    localparam int         SYNC = 2;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic       rx_overrun, frame_abort;

    always #5 clk = ~clk;

    spi_slave_axis #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .rx_overrun   (rx_overrun),
        .frame_abort  (frame_abort)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         abort_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mosi_b[8];
    logic [7:0] rsp_b[8];
    logic [7:0] miso_b[8];
    bit         rsp_en[8];
    bit         ovr_b[8];

    always @(posedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_s_tready", s_axis_tready, 1);
        chk("rst_miso", spi_miso, 0);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_abort", frame_abort, 0);
    endtask

    task automatic push(input logic [7:0] v);
        bit ok = 0;
        s_axis_tdata  = v;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (s_axis_tready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic xfer(input int nbytes, input int extra, input int half, input int rst_at);
        int total, i, k;
        total = nbytes * 8 + extra;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
        chk("oe_active", spi_miso_oe, 1);
        chk("tready_after_load", s_axis_tready, 1);
        for (int b = 0; b < total; b++) begin
            i = b / 8;
            k = b % 8;
            spi_mosi = mosi_b[i][7-k];
            repeat (half) @(negedge clk);
            if (k == 0 && b > 0) ovr_b[i-1] = rx_overrun;
            if (b == rst_at) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk_reset_vals();
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
            end
            miso_b[i][7-k] = spi_miso;
            spi_sclk = 1'b1;
            if (k == 0 && i + 1 < nbytes && rsp_en[i+1]) push(rsp_b[i+1]);
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        if (extra == 0 && nbytes > 0) ovr_b[nbytes-1] = rx_overrun;
        spi_cs_n = 1'b1;
        repeat (SYNC + 6) @(negedge clk);
        chk("oe_idle", spi_miso_oe, 0);
    endtask

    task automatic clear_rsp();
        for (int i = 0; i < 8; i++) begin
            rsp_en[i] = 0;
            rsp_b[i]  = 8'h00;
        end
    endtask

    task automatic rand_frame(input int nbytes);
        clear_rsp();
        for (int i = 0; i < nbytes; i++) begin
            mosi_b[i] = 8'($urandom);
            rsp_en[i] = 1'($urandom);
            rsp_b[i]  = 8'($urandom);
        end
    endtask

    task automatic expect_frame(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back(mosi_b[i]);
            chk("miso_byte", miso_b[i], rsp_en[i] ? rsp_b[i] : IDLE);
        end
    endtask

    task automatic compare_beats();
        int n;
        chk("beat_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int j = 0; j < n; j++) chk("beat_data", got_q[j], exp_q[j]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int a0, nb;
        bit m_full, m_ovr;
        logic [7:0] held;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        clear_rsp();
        mosi_b[0] = 8'h00; mosi_b[1] = 8'h12;
        mosi_b[2] = 8'h34; mosi_b[3] = 8'h56;
        xfer(4, 0, 4, -1);
        expect_frame(4);
        compare_beats();

        clear_rsp();
        rsp_en[0] = 1; rsp_b[0] = 8'hA5;
        mosi_b[0] = 8'h9C; mosi_b[1] = 8'h3F;
        push(8'hA5);
        chk("tready_full", s_axis_tready, 0);
        xfer(2, 0, 4, -1);
        expect_frame(2);
        compare_beats();

        clear_rsp();
        a0 = abort_cnt;
        mosi_b[0] = 8'hC3;
        xfer(0, 5, 4, -1);
        chk("abort_pulses", abort_cnt - a0, 1);
        compare_beats();
        mosi_b[0] = 8'h7E;
        xfer(1, 0, 4, -1);
        expect_frame(1);
        compare_beats();

        a0 = abort_cnt;
        for (int f = 0; f < 8; f++) begin
            nb = $urandom_range(4, 1);
            rand_frame(nb);
            if (rsp_en[0]) push(rsp_b[0]);
            xfer(nb, 0, $urandom_range(6, 4), -1);
            expect_frame(nb);
            compare_beats();
        end
        chk("no_abort_full_frames", abort_cnt - a0, 0);

        clear_rsp();
        m_axis_tready = 1'b0;
        mosi_b[0] = 8'h11; mosi_b[1] = 8'h22; mosi_b[2] = 8'h33;
        xfer(3, 0, 4, -1);
        m_full = 0; m_ovr = 0; held = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (!m_full) begin
                m_full = 1;
                held = mosi_b[i];
            end else begin
                m_ovr = 1;
            end
            chk("overrun_after_byte", ovr_b[i], m_ovr);
        end
        chk("held_tvalid", m_axis_tvalid, 1);
        chk("held_tdata", m_axis_tdata, held);
        compare_beats();
        m_axis_tready = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(held);
        compare_beats();
        chk("tvalid_drained", m_axis_tvalid, 0);
        chk("overrun_sticky", rx_overrun, 1);

        clear_rsp();
        a0 = abort_cnt;
        mosi_b[0] = 8'($urandom); mosi_b[1] = 8'($urandom);
        xfer(2, 0, 8, 3);
        compare_beats();
        chk("no_abort_after_reset", abort_cnt - a0, 0);
        rand_frame(3);
        if (rsp_en[0]) push(rsp_b[0]);
        xfer(3, 0, 8, -1);
        expect_frame(3);
        compare_beats();
        chk("overrun_cleared", rx_overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
